// File: rtl/periph_arbiter.sv
// Two-master round-robin arbiter in front of a single valid/ready slave port.
// One request is latched per master and one slave transaction is outstanding at a time.
module periph_arbiter #(
  parameter int timeout   = 1024,
  parameter int timeout_w = $clog2(timeout + 1)
) (
  input  logic        clock,
  input  logic        reset,
  // master 0: instruction fetch
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_error,
  // master 1: data
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_error,
  // slave
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready
);

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  localparam logic [timeout_w-1:0] LastCount = timeout_w'(timeout - 1);

  state_t               state_q, state_d;
  req_t                 req0_q, req1_q, granted;
  logic                 pend0_q, pend1_q;
  logic                 last_grant_q, grant_q;
  logic                 grant_sel, do_grant;
  logic                 done_ok, done_to, done;
  logic [31:0]          resp_data;
  logic [timeout_w-1:0] count_q;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    do_grant  = 1'b0;
    grant_sel = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend0_q || pend1_q) begin
          do_grant  = 1'b1;
          // with both pending, the master that did not win last time goes first
          grant_sel = (pend0_q && pend1_q) ? ~last_grant_q : pend1_q;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (s_ready) begin
          done_ok = 1'b1;
          state_d = ST_IDLE;
        end else if (count_q == LastCount) begin
          done_to = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done      = done_ok | done_to;
  assign granted   = grant_sel ? req1_q : req0_q;
  assign resp_data = done_ok ? s_rdata : 32'd0;

  // Request capture: a valid while already pending is a protocol violation and dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      req0_q  <= '0;
      req1_q  <= '0;
    end else begin
      if (m0_valid && !pend0_q) begin
        req0_q  <= '{instr: m0_instr, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
        pend0_q <= 1'b1;
      end else if (done && !grant_q) begin
        pend0_q <= 1'b0;
      end
      if (m1_valid && !pend1_q) begin
        req1_q  <= '{instr: m1_instr, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
        pend1_q <= 1'b1;
      end else if (done && grant_q) begin
        pend1_q <= 1'b0;
      end
    end
  end

  // Slave side: granted fields hold from ISSUE until the next grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_valid      <= 1'b0;
      s_instr      <= 1'b0;
      s_addr       <= 32'd0;
      s_wdata      <= 32'd0;
      s_wstrb      <= 4'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      count_q      <= '0;
    end else begin
      s_valid <= do_grant;
      if (do_grant) begin
        grant_q      <= grant_sel;
        last_grant_q <= grant_sel;
        s_instr      <= granted.instr;
        s_addr       <= granted.addr;
        s_wdata      <= granted.wdata;
        s_wstrb      <= granted.wstrb;
      end
      if (state_q == ST_ISSUE)     count_q <= '0;
      else if (state_q == ST_WAIT) count_q <= count_q + timeout_w'(1);
    end
  end

  // Response side: single-cycle pulses, data forced to zero outside the ready cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m0_ready <= 1'b0;
      m0_error <= 1'b0;
      m0_rdata <= 32'd0;
      m1_ready <= 1'b0;
      m1_error <= 1'b0;
      m1_rdata <= 32'd0;
    end else begin
      m0_ready <= done && !grant_q;
      m0_error <= done_to && !grant_q;
      m0_rdata <= (done && !grant_q) ? resp_data : 32'd0;
      m1_ready <= done && grant_q;
      m1_error <= done_to && grant_q;
      m1_rdata <= (done && grant_q) ? resp_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_periph_arbiter.sv
// Bench for periph_arbiter: table of single transactions against a scripted slave,
// plus hand sequences for arbitration order and reset in the middle of a transaction.
module tb_periph_arbiter;

  localparam int Timeout = 8;

  logic        clock, reset;
  logic        m0_valid, m0_instr, m0_ready, m0_error;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready, m1_error;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  periph_arbiter #(.timeout(Timeout)) dut (
    .clock(clock), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_error(m0_error),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_error(m1_error),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready)
  );

  typedef struct {
    int          m;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;        // slave answer delay after s_valid; 0 = never answers
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;    // cycles from request to ready pulse
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sreq_t;

  exp_t  exp0_q[$];
  exp_t  exp1_q[$];
  sreq_t grant_log[$];
  int    n_cmp, n_fail, cyc, slave_lat;
  int    ready_cyc[2];
  int    ready_cnt[2];
  bit    slave_busy;
  vec_t  vecs[8];

  function automatic logic [31:0] slave_fn(input logic [31:0] a);
    return a + 32'd1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_valids();
    m0_valid = 1'b0;
    m1_valid = 1'b0;
  endtask

  task automatic drive_req(input int m, input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
    if (m == 0) begin
      m0_valid = 1'b1; m0_instr = instr; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end else begin
      m1_valid = 1'b1; m1_instr = instr; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end
  endtask

  task automatic push_exp(input int m, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    if (m == 0) exp0_q.push_back(e);
    else        exp1_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_s_valid"}, 32'(s_valid), 32'd0);
    check({name, "_s_addr"}, s_addr, 32'd0);
    check({name, "_m0_ready"}, 32'(m0_ready), 32'd0);
    check({name, "_m1_ready"}, 32'(m1_ready), 32'd0);
    check({name, "_m0_error"}, 32'(m0_error), 32'd0);
    check({name, "_m1_rdata"}, m1_rdata, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_valids();
    tick();
    tick();
    check_outputs_zero("reset");
    exp0_q.delete();
    exp1_q.delete();
    grant_log.delete();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp0_q.size() + exp1_q.size() > 0 || slave_busy) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 32'(exp0_q.size() + exp1_q.size() + int'(slave_busy)), 32'd0);
    repeat (2) tick();
  endtask

  task automatic do_txn(input vec_t v, input string name);
    int    t0;
    sreq_t g;
    slave_lat = v.lat;
    drive_req(v.m, v.instr, v.addr, v.wdata, v.wstrb);
    push_exp(v.m, v.exp_rdata, v.exp_err);
    t0 = cyc;
    tick();
    clear_valids();
    wait_drain(name, 40);
    check({name, "_latency"}, 32'(ready_cyc[v.m] - t0), 32'(v.exp_cyc));
    check({name, "_grants"}, 32'(grant_log.size()), 32'd1);
    if (grant_log.size() > 0) begin
      g = grant_log.pop_front();
      check({name, "_s_instr"}, 32'(g.instr), 32'(v.instr));
      check({name, "_s_addr"}, g.addr, v.addr);
      check({name, "_s_wdata"}, g.wdata, v.wdata);
      check({name, "_s_wstrb"}, 32'(g.wstrb), 32'(v.wstrb));
    end
    grant_log.delete();
  endtask

  task automatic mon_port(input int m, input logic rdy, input logic err, input logic [31:0] rd);
    exp_t e;
    if (rdy === 1'b1) begin
      ready_cnt[m]++;
      ready_cyc[m] = cyc;
      if ((m == 0 && exp0_q.size() == 0) || (m == 1 && exp1_q.size() == 0)) begin
        n_cmp++;
        n_fail++;
        $display("FAIL m%0d_unexpected_ready: actual ready=1 required ready=0 (nothing outstanding)", m);
      end else begin
        if (m == 0) e = exp0_q.pop_front();
        else        e = exp1_q.pop_front();
        check($sformatf("m%0d_rdata", m), rd, e.rdata);
        check($sformatf("m%0d_error", m), 32'(err), 32'(e.err));
      end
    end else begin
      check($sformatf("m%0d_idle_rdata", m), rd, 32'd0);
      check($sformatf("m%0d_idle_error", m), 32'(err), 32'd0);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Scripted slave: logs each grant and answers slave_fn(addr) slave_lat cycles later.
  initial begin
    logic [31:0] a;
    s_ready    = 1'b0;
    s_rdata    = 32'd0;
    slave_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (s_valid === 1'b1) begin
        grant_log.push_back('{s_instr, s_addr, s_wdata, s_wstrb});
        a = s_addr;
        if (slave_lat > 0) begin
          slave_busy = 1'b1;
          repeat (slave_lat) @(posedge clock);
          #1;
          s_ready = 1'b1;
          s_rdata = slave_fn(a);
          @(posedge clock);
          #1;
          s_ready    = 1'b0;
          s_rdata    = 32'd0;
          slave_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      mon_port(0, m0_ready, m0_error, m0_rdata);
      mon_port(1, m1_ready, m1_error, m1_rdata);
    end
  end

  initial begin
    bit    re0, re1;
    int    n, rc;
    sreq_t g;

    vecs[0] = '{0, 1'b1, 32'h0000_0000, 32'h0,         4'h0, 1, 32'h0000_0001, 1'b0, 4};
    vecs[1] = '{1, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 4'hF, 1, 32'h0000_4001, 1'b0, 4};
    vecs[2] = '{0, 1'b1, 32'h0000_0100, 32'h0,         4'h0, 3, 32'h0000_0101, 1'b0, 6};
    vecs[3] = '{1, 1'b0, 32'h0000_200C, 32'h0,         4'h0, 8, 32'h0000_200D, 1'b0, 11};
    vecs[4] = '{0, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 32'h0000_0000, 1'b1, 11};
    vecs[5] = '{1, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 9, 32'h0000_0000, 1'b1, 11};
    vecs[6] = '{1, 1'b0, 32'h0000_BFF8, 32'h0,         4'h0, 7, 32'h0000_BFF9, 1'b0, 10};
    vecs[7] = '{0, 1'b0, 32'h0000_4004, 32'h1234_5678, 4'h3, 2, 32'h0000_4005, 1'b0, 5};

    n_cmp = 0; n_fail = 0; slave_lat = 1;
    ready_cnt[0] = 0; ready_cnt[1] = 0; ready_cyc[0] = 0; ready_cyc[1] = 0;
    reset = 1'b1;
    m0_instr = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_wstrb = 4'd0;
    m1_instr = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_wstrb = 4'd0;
    clear_valids();
    do_reset();

    for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests after reset, each master re-requesting in its ready cycle.
    do_reset();
    slave_lat = 1;
    drive_req(0, 1'b0, 32'h0000_00A0, 32'h0, 4'h0);
    drive_req(1, 1'b0, 32'h0000_00B0, 32'h0, 4'h0);
    push_exp(0, slave_fn(32'h0000_00A0), 1'b0);
    push_exp(1, slave_fn(32'h0000_00B0), 1'b0);
    tick();
    clear_valids();
    re0 = 1'b0; re1 = 1'b0; n = 0;
    while (!(re0 && re1) && n < 60) begin
      if (m0_ready === 1'b1 && !re0) begin
        drive_req(0, 1'b0, 32'h0000_00A4, 32'h0, 4'h0);
        push_exp(0, slave_fn(32'h0000_00A4), 1'b0);
        re0 = 1'b1;
      end
      if (m1_ready === 1'b1 && !re1) begin
        drive_req(1, 1'b0, 32'h0000_00B4, 32'h0, 4'h0);
        push_exp(1, slave_fn(32'h0000_00B4), 1'b0);
        re1 = 1'b1;
      end
      tick();
      clear_valids();
      n++;
    end
    wait_drain("rr", 60);
    check("rr_reissued", 32'(re0 && re1), 32'd1);
    check("rr_grant_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      g = grant_log.pop_front(); check("rr_grant0_m0", g.addr, 32'h0000_00A0);
      g = grant_log.pop_front(); check("rr_grant1_m1", g.addr, 32'h0000_00B0);
      g = grant_log.pop_front(); check("rr_grant2_m0", g.addr, 32'h0000_00A4);
      g = grant_log.pop_front(); check("rr_grant3_m1", g.addr, 32'h0000_00B4);
    end
    grant_log.delete();

    // Reset while the slave access is outstanding: nothing may complete afterwards.
    slave_lat = 0;
    drive_req(1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    tick();
    clear_valids();
    repeat (3) tick();
    check("midreset_s_addr_before", s_addr, 32'h0000_0300);
    rc = ready_cnt[1];
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    tick();
    tick();
    reset = 1'b0;
    repeat (12) tick();
    check("midreset_no_ready", 32'(ready_cnt[1] - rc), 32'd0);
    check("midreset_grants", 32'(grant_log.size()), 32'd1);
    grant_log.delete();
    do_txn('{1, 1'b0, 32'h0000_0304, 32'h0, 4'h0, 2, 32'h0000_0305, 1'b0, 5}, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
